mvu_apb_csr_bridge: RTL



---
 rtl/mvu_apb_csr_bridge_pkg.sv | 31 +++
 rtl/mvu_apb_csr_bridge_if.sv | 25 ++
 rtl/mvu_csr_decode.sv | 18 +
 rtl/mvu_apb_csr_bridge.sv | 97 +++++++++
 4 files changed

// File: rtl/mvu_apb_csr_bridge_pkg.sv
// Shared types, CSR map constants and helpers for the MVU APB-to-CSR bridge.
package mvu_apb_csr_bridge_pkg;

   localparam int NMVU           = 8;
   localparam int BMVUCSRA       = 12;
   localparam int APB_ADDR_WIDTH = 15;
   localparam int APB_DATA_WIDTH = 32;
   localparam int APB_STRB_WIDTH = 4;

   typedef logic [APB_ADDR_WIDTH-1:0] apb_addr_t;
   typedef logic [APB_DATA_WIDTH-1:0] apb_data_t;
   typedef logic [APB_STRB_WIDTH-1:0] apb_strb_t;
   typedef logic [BMVUCSRA-1:0]       mvu_csr_t;
   typedef logic [$clog2(NMVU)-1:0]   mvu_idx_t;

   localparam mvu_csr_t CSR_MVUWBASEPTR   = 12'hF20;
   localparam mvu_csr_t CSR_MVUIBASEPTR   = 12'hF21;
   localparam mvu_csr_t CSR_MVUPRECISION  = 12'hF53;
   localparam mvu_csr_t CSR_MVUSTATUS     = 12'hF54;
   localparam mvu_csr_t CSR_MVUUSEHPADDER = 12'hF69;
   localparam mvu_csr_t CSR_FIRST         = CSR_MVUWBASEPTR;
   localparam mvu_csr_t CSR_LAST          = CSR_MVUUSEHPADDER;

   typedef enum logic [1:0] {BR_IDLE, BR_ISSUE, BR_RESP, BR_ERR} apb_br_state_t;

   function automatic logic [NMVU-1:0] mvu_onehot(input mvu_idx_t idx);
      mvu_onehot      = '0;
      mvu_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/mvu_apb_csr_bridge_if.sv
// APB completer bus. Handshake: a transfer starts with psel & !penable (setup),
// then holds psel & penable until the completer returns pready for one cycle.
interface mvu_apb_csr_bridge_if;
   import mvu_apb_csr_bridge_pkg::*;

   logic      psel;
   logic      penable;
   logic      pwrite;
   apb_addr_t paddr;
   apb_data_t pwdata;
   apb_strb_t pstrb;
   apb_data_t prdata;
   logic      pready;
   logic      pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/mvu_csr_decode.sv
// Combinational legality check of an APB access against the MVU CSR map.
module mvu_csr_decode
   import mvu_apb_csr_bridge_pkg::*;
(
   input  mvu_csr_t  csr,
   input  logic      we,
   input  apb_strb_t strb,
   output logic      err
);

   always_comb begin
      err = 1'b0;
      if (csr < CSR_FIRST || csr > CSR_LAST) err = 1'b1;
      if (we && strb != '1)                  err = 1'b1;
      if (we && csr == CSR_MVUSTATUS)        err = 1'b1;
   end

endmodule

// File: rtl/mvu_apb_csr_bridge.sv
// APB completer that turns each transfer into one req/ack CSR transaction
// toward the selected MVU, with decode rejection and an ack timeout.
module mvu_apb_csr_bridge
   import mvu_apb_csr_bridge_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   mvu_apb_csr_bridge_if.slave    apb,
   output logic [NMVU-1:0]        csr_req,
   output logic                   csr_we,
   output mvu_csr_t               csr_addr,
   output apb_data_t              csr_wdata,
   input  logic [NMVU-1:0]        csr_ack,
   input  logic [NMVU*32-1:0]     csr_rdata,
   output apb_br_state_t          state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic          dec_err;
   logic [CW-1:0] cnt;
   mvu_idx_t      idx_q;
   apb_data_t     ack_rdata;

   mvu_csr_decode u_decode (
      .csr  (apb.paddr[BMVUCSRA-1:0]),
      .we   (apb.pwrite),
      .strb (apb.pstrb),
      .err  (dec_err)
   );

   assign ack_rdata = csr_rdata[{idx_q, 5'd0} +: 32];

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BR_IDLE;
         csr_req     <= '0;
         csr_we      <= 1'b0;
         csr_addr    <= '0;
         csr_wdata   <= '0;
         apb.pready  <= 1'b0;
         apb.pslverr <= 1'b0;
         apb.prdata  <= '0;
         cnt         <= '0;
         idx_q       <= '0;
      end else begin
         case (state)
            BR_IDLE: begin
               if (apb.psel && !apb.penable) begin
                  idx_q <= apb.paddr[APB_ADDR_WIDTH-1:BMVUCSRA];
                  if (dec_err) begin
                     // Decode errors complete in the access phase with no wait states.
                     state       <= BR_ERR;
                     apb.pready  <= 1'b1;
                     apb.pslverr <= 1'b1;
                     apb.prdata  <= '0;
                  end else begin
                     state     <= BR_ISSUE;
                     csr_req   <= mvu_onehot(apb.paddr[APB_ADDR_WIDTH-1:BMVUCSRA]);
                     csr_we    <= apb.pwrite;
                     csr_addr  <= apb.paddr[BMVUCSRA-1:0];
                     csr_wdata <= apb.pwdata;
                     cnt       <= '0;
                  end
               end
            end
            BR_ISSUE: begin
               if (csr_ack[idx_q]) begin
                  state       <= BR_RESP;
                  csr_req     <= '0;
                  apb.pready  <= 1'b1;
                  apb.pslverr <= 1'b0;
                  apb.prdata  <= csr_we ? '0 : ack_rdata;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state       <= BR_ERR;
                  csr_req     <= '0;
                  apb.pready  <= 1'b1;
                  apb.pslverr <= 1'b1;
                  apb.prdata  <= '0;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            BR_RESP, BR_ERR: begin
               state       <= BR_IDLE;
               apb.pready  <= 1'b0;
               apb.pslverr <= 1'b0;
               apb.prdata  <= '0;
            end
            default: state <= BR_IDLE;
         endcase
      end
   end

endmodule
